// File: rtl/bh_run_ctrl_if.sv
// Host instruction stream for bh_run_ctrl: one instruction per valid/ready beat,
// with a last flag on the final instruction of the program.
interface bh_run_ctrl_if #(
    parameter int unsigned INSTR_W = 3
);
    logic               in_valid;
    logic [INSTR_W-1:0] in_data;
    logic               in_last;
    logic               in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/bh_run_ctrl.sv
// Run controller for the brainhack core: loads the program, zeroes the tape,
// then runs the core until its PC leaves the program or the cycle budget is spent.
module bh_run_ctrl #(
    parameter int unsigned INSTR_W = 3,
    parameter int unsigned PRG_AW  = 8,
    parameter int unsigned TAPE_AW = 8,
    parameter int unsigned TAPE_DW = 8,
    parameter int unsigned CYC_W   = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    bh_run_ctrl_if.slave       host,
    output logic               o_prg_we,
    output logic [PRG_AW-1:0]  o_prg_addr,
    output logic [INSTR_W-1:0] o_prg_data,
    output logic               o_tape_we,
    output logic [TAPE_AW-1:0] o_tape_addr,
    output logic [TAPE_DW-1:0] o_tape_data,
    input  logic [PRG_AW-1:0]  i_core_pc,
    output logic               o_core_rst,
    output logic               o_core_en,
    input  logic [CYC_W-1:0]   i_cycle_limit,
    output logic [PRG_AW-1:0]  o_prg_len,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_RUN,
        ST_HALT
    } state_e;

    localparam logic [PRG_AW-1:0]  LEN_MAX  = '1;
    localparam logic [PRG_AW-1:0]  LAST_IDX = LEN_MAX - PRG_AW'(1);
    localparam logic [TAPE_AW-1:0] TAPE_END = '1;
    localparam logic [CYC_W-1:0]   CYC_SAT  = '1;

    state_e               state_q, state_d;
    logic                 prg_we_q, prg_we_d;
    logic [PRG_AW-1:0]    prg_addr_q, prg_addr_d;
    logic [INSTR_W-1:0]   prg_data_q, prg_data_d;
    logic                 tape_we_q, tape_we_d;
    logic [TAPE_AW-1:0]   tape_addr_q, tape_addr_d;
    logic [PRG_AW-1:0]    prg_len_q, prg_len_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic                 core_rst_q, core_rst_d;
    logic                 core_en_q, core_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 in_ready_c;
    logic                 beat_c;
    logic [CYC_W:0]       cyc_inc_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        prg_we_d    = 1'b0;
        prg_addr_d  = prg_addr_q;
        prg_data_d  = prg_data_q;
        tape_we_d   = 1'b0;
        tape_addr_d = tape_addr_q;
        prg_len_d   = prg_len_q;
        cyc_d       = cyc_q;
        timeout_d   = timeout_q;
        in_ready_c  = (state_q == ST_LOAD) && (prg_len_q != LEN_MAX);
        beat_c      = in_ready_c && host.in_valid;
        // One extra bit so a saturated counter can never alias onto the limit
        cyc_inc_c   = {1'b0, cyc_q} + (CYC_W + 1)'(1);

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (i_start) begin
                    state_d   = ST_LOAD;
                    prg_len_d = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (beat_c) begin
                    prg_we_d   = 1'b1;
                    prg_addr_d = prg_len_q;
                    prg_data_d = host.in_data;
                    prg_len_d  = prg_len_q + PRG_AW'(1);
                    if (host.in_last || (prg_len_q == LAST_IDX)) begin
                        state_d     = ST_CLEAR;
                        tape_we_d   = 1'b1;
                        tape_addr_d = '0;
                    end
                end
            end
            ST_CLEAR: begin
                if (tape_addr_q == TAPE_END) begin
                    state_d = ST_RUN;
                    cyc_d   = '0;
                end else begin
                    tape_we_d   = 1'b1;
                    tape_addr_d = tape_addr_q + TAPE_AW'(1);
                end
            end
            ST_RUN: begin
                if (cyc_q != CYC_SAT) begin
                    cyc_d = cyc_inc_c[CYC_W-1:0];
                end
                // PC completion takes priority over budget expiry
                if (i_core_pc == prg_len_q) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b0;
                end else if ((i_cycle_limit != '0) && (cyc_inc_c == {1'b0, i_cycle_limit})) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d == ST_LOAD) || (state_d == ST_CLEAR) || (state_d == ST_RUN);
        core_en_d  = (state_d == ST_RUN);
        core_rst_d = !core_en_d;
        done_d     = (state_d == ST_HALT);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            prg_we_q    <= 1'b0;
            prg_addr_q  <= '0;
            prg_data_q  <= '0;
            tape_we_q   <= 1'b0;
            tape_addr_q <= '0;
            prg_len_q   <= '0;
            cyc_q       <= '0;
            core_rst_q  <= 1'b1;
            core_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prg_we_q    <= prg_we_d;
            prg_addr_q  <= prg_addr_d;
            prg_data_q  <= prg_data_d;
            tape_we_q   <= tape_we_d;
            tape_addr_q <= tape_addr_d;
            prg_len_q   <= prg_len_d;
            cyc_q       <= cyc_d;
            core_rst_q  <= core_rst_d;
            core_en_q   <= core_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign host.in_ready = in_ready_c;
    assign o_prg_we      = prg_we_q;
    assign o_prg_addr    = prg_addr_q;
    assign o_prg_data    = prg_data_q;
    assign o_tape_we     = tape_we_q;
    assign o_tape_addr   = tape_addr_q;
    assign o_tape_data   = '0;
    assign o_core_rst    = core_rst_q;
    assign o_core_en     = core_en_q;
    assign o_prg_len     = prg_len_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_bh_run_ctrl.sv
// Self-checking bench for bh_run_ctrl: scenario table, directed abort/saturation
// sequences, and randomized programs checked against a halt-rule model.
module tb_bh_run_ctrl;
    localparam int unsigned INSTR_W = 3;
    localparam int unsigned PRG_AW  = 8;
    localparam int unsigned TAPE_AW = 8;
    localparam int unsigned TAPE_DW = 8;
    localparam int unsigned CYC_W   = 16;
    localparam int          NVEC    = 6;

    logic               i_clock = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_start = 1'b0;
    logic               o_prg_we;
    logic [PRG_AW-1:0]  o_prg_addr;
    logic [INSTR_W-1:0] o_prg_data;
    logic               o_tape_we;
    logic [TAPE_AW-1:0] o_tape_addr;
    logic [TAPE_DW-1:0] o_tape_data;
    logic [PRG_AW-1:0]  i_core_pc;
    logic               o_core_rst;
    logic               o_core_en;
    logic [CYC_W-1:0]   i_cycle_limit;
    logic [PRG_AW-1:0]  o_prg_len;
    logic               o_busy;
    logic               o_done;
    logic               o_timeout;

    bh_run_ctrl_if #(.INSTR_W(INSTR_W)) host_if ();

    bh_run_ctrl #(
        .INSTR_W(INSTR_W), .PRG_AW(PRG_AW), .TAPE_AW(TAPE_AW),
        .TAPE_DW(TAPE_DW), .CYC_W(CYC_W)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .host         (host_if.slave),
        .o_prg_we     (o_prg_we),
        .o_prg_addr   (o_prg_addr),
        .o_prg_data   (o_prg_data),
        .o_tape_we    (o_tape_we),
        .o_tape_addr  (o_tape_addr),
        .o_tape_data  (o_tape_data),
        .i_core_pc    (i_core_pc),
        .o_core_rst   (o_core_rst),
        .o_core_en    (o_core_en),
        .i_cycle_limit(i_cycle_limit),
        .o_prg_len    (o_prg_len),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int n_offer;
        int last_idx;
        int stall_at;
        int limit;
        int pc_mode;      // 0: hold pc_hold, 1: pc follows run cycle index
        int pc_hold;
        bit start_in_run;
        int exp_len;
        int exp_to;
        int exp_cyc;
    } vec_t;

    int                 errors = 0;
    int                 checks = 0;
    int                 cyc = 0;
    wr_t                prg_q[$];
    wr_t                tape_q[$];
    logic [INSTR_W-1:0] prog_data[300];
    int                 pcs[300];
    vec_t               vecs[NVEC];

    // Observe RAM write ports once per cycle, just after the edge
    always begin
        @(posedge i_clock);
        cyc++;
        #1;
        if (o_prg_we)  prg_q.push_back('{addr: o_prg_addr, data: 8'(o_prg_data)});
        if (o_tape_we) tape_q.push_back('{addr: o_tape_addr, data: o_tape_data});
    end

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_prg"},    {o_prg_we, o_prg_addr, o_prg_data}, 0);
        chk({tag, "_tape"},   {o_tape_we, o_tape_addr, o_tape_data}, 0);
        chk({tag, "_core"},   {o_core_rst, o_core_en}, 2'b10);
        chk({tag, "_len"},    o_prg_len, 0);
        chk({tag, "_status"}, {o_busy, o_done, o_timeout}, 0);
        chk({tag, "_ready"},  host_if.in_ready, 0);
    endtask

    // Halt rule: first cycle t where PC equals length, else where t+1 reaches a nonzero limit
    task automatic model_halt(input int n, input int limit, output int to, output int ncyc);
        to = 0;
        ncyc = 300;
        for (int t = 0; t < 300; t++) begin
            if (pcs[t] == n) begin
                to = 0; ncyc = t + 1; break;
            end
            if (limit != 0 && t + 1 == limit) begin
                to = 1; ncyc = t + 1; break;
            end
        end
    endtask

    task automatic do_load(input int n_offer, input int last_idx, input int stall_at,
                           input bit rnd_stall, input int exp_len);
        int acc = 0;
        int b = 0;
        bit fin = 1'b0;
        bit stalled = 1'b0;
        bit rdy;
        int k;
        int bad;
        prg_q.delete();
        tape_q.delete();
        host_if.in_valid = 1'b1;
        host_if.in_last  = 1'b0;
        chk("ready_idle", host_if.in_ready, 0);
        step();
        chk("no_wr_idle", o_prg_we, 0);
        host_if.in_valid = 1'b0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("start_status", {o_busy, o_done, o_timeout, o_core_rst}, 4'b1001);
        chk("start_len", o_prg_len, 0);
        while (!fin && b < n_offer) begin
            if ((b == stall_at && !stalled) || (rnd_stall && $urandom_range(0, 2) == 0)) begin
                stalled = 1'b1;
                host_if.in_valid = 1'b0;
                step();
                chk("stall_no_wr", o_prg_we, 0);
                continue;
            end
            host_if.in_valid = 1'b1;
            host_if.in_data  = prog_data[b];
            host_if.in_last  = (b == last_idx);
            rdy = host_if.in_ready;
            step();
            if (!rdy) begin
                chk("ready_load", rdy, 1);
                break;
            end
            chk("prg_wr", {o_prg_we, o_prg_addr, o_prg_data}, {1'b1, 8'(b), prog_data[b]});
            acc++;
            if (b == last_idx || b == 254) fin = 1'b1;
            b++;
        end
        k = cyc;
        chk("accepted", acc, exp_len);
        chk("clear_first", {o_tape_we, o_tape_addr, o_prg_we}, {1'b1, 8'd0, 1'b1});
        chk("ready_clear", host_if.in_ready, 0);
        host_if.in_valid = 1'b0;
        host_if.in_last  = 1'b0;
        for (int w = 0; w < 400; w++) begin
            if (o_core_en) break;
            step();
        end
        chk("run_entry", {o_core_en, o_core_rst, o_busy}, 3'b101);
        chk("clear_len", cyc - k, 256);
        chk("prg_len", o_prg_len, exp_len);
        chk("prg_wr_count", prg_q.size(), exp_len);
        bad = 0;
        foreach (prg_q[i]) if (prg_q[i] !== {8'(i), 8'(prog_data[i])}) bad++;
        chk("prg_wr_seq", bad, 0);
        chk("tape_wr_count", tape_q.size(), 256);
        bad = 0;
        foreach (tape_q[i]) if (tape_q[i] !== {8'(i), 8'd0}) bad++;
        chk("tape_wr_seq", bad, 0);
    endtask

    task automatic run_phase(input int n, input int limit, input bit start_pulse,
                             input int exp_to, input int exp_cyc);
        i_cycle_limit = CYC_W'(limit);
        for (int t = 0; t < exp_cyc; t++) begin
            chk("run_en", o_core_en, 1);
            if (!o_core_en) break;
            i_core_pc = PRG_AW'(pcs[t]);
            i_start   = start_pulse && (t == 1);
            step();
        end
        i_start = 1'b0;
        chk("halt_core", {o_core_en, o_core_rst, o_busy}, 3'b010);
        chk("halt_done", o_done, 1);
        chk("halt_timeout", o_timeout, exp_to);
        chk("halt_len", o_prg_len, n);
    endtask

    initial begin
        int lowcnt;
        int n;
        int lim;
        int eto;
        int ecyc;
        host_if.in_valid = 1'b0;
        host_if.in_data  = '0;
        host_if.in_last  = 1'b0;
        i_core_pc        = '0;
        i_cycle_limit    = '0;

        vecs[0] = '{3,   2,  1,  0, 1, 0, 1'b0, 3,   0, 4};
        vecs[1] = '{3,   2, -1, 10, 0, 0, 1'b1, 3,   1, 10};
        vecs[2] = '{1,   0, -1,  1, 0, 0, 1'b0, 1,   1, 1};
        vecs[3] = '{2,   1, -1,  3, 1, 0, 1'b0, 2,   0, 3};
        vecs[4] = '{300, -1, -1, 0, 1, 0, 1'b0, 255, 0, 256};
        vecs[5] = '{1,   0, -1,  0, 0, 1, 1'b1, 1,   0, 1};

        // Asynchronous reset between clock edges
        #2 i_reset = 1'b1;
        #1 chk_reset("rst_async");
        repeat (2) step();
        i_reset = 1'b0;
        step();
        chk_reset("rst_idle");

        // Abort during tape clear
        prog_data[0] = 3'd4;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        host_if.in_valid = 1'b1;
        host_if.in_data  = prog_data[0];
        host_if.in_last  = 1'b1;
        step();
        host_if.in_valid = 1'b0;
        host_if.in_last  = 1'b0;
        for (int w = 0; w < 400; w++) begin
            if (o_tape_we && o_tape_addr == 8'd100) break;
            step();
        end
        chk("abort_at_100", {o_tape_we, o_tape_addr}, {1'b1, 8'd100});
        #3 i_reset = 1'b1;
        #1 chk_reset("rst_abort");
        prg_q.delete();
        tape_q.delete();
        repeat (2) step();
        i_reset = 1'b0;
        repeat (3) step();
        chk("no_wr_after_rst", tape_q.size() + prg_q.size(), 0);
        chk("idle_after_abort", {o_busy, o_core_en, o_core_rst}, 3'b001);

        // Scenario table
        for (int i = 0; i < NVEC; i++) begin
            for (int j = 0; j < 300; j++) begin
                prog_data[j] = INSTR_W'($urandom);
                pcs[j] = (vecs[i].pc_mode == 1) ? j : vecs[i].pc_hold;
            end
            if (i == 0) begin
                prog_data[0] = 3'd5;
                prog_data[1] = 3'd2;
                prog_data[2] = 3'd7;
            end
            do_load(vecs[i].n_offer, vecs[i].last_idx, vecs[i].stall_at, 1'b0, vecs[i].exp_len);
            run_phase(vecs[i].exp_len, vecs[i].limit, vecs[i].start_in_run,
                      vecs[i].exp_to, vecs[i].exp_cyc);
        end

        // Randomized programs, stalls, budgets and PC traces
        for (int r = 0; r < 8; r++) begin
            n   = int'($urandom_range(1, 12));
            lim = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
            for (int j = 0; j < 300; j++) begin
                prog_data[j] = INSTR_W'($urandom);
                pcs[j] = int'($urandom_range(0, n));
            end
            pcs[299] = n;
            model_halt(n, lim, eto, ecyc);
            do_load(n, n - 1, -1, 1'b1, n);
            run_phase(n, lim, 1'(($urandom_range(0, 1))), eto, ecyc);
        end

        // Unlimited budget: counter must saturate rather than wrap
        for (int j = 0; j < 2; j++) prog_data[j] = INSTR_W'($urandom);
        do_load(2, 1, -1, 1'b0, 2);
        i_cycle_limit = '0;
        i_core_pc = '0;
        lowcnt = 0;
        for (int t = 0; t < 70000; t++) begin
            step();
            if (!o_core_en) lowcnt++;
        end
        chk("unlimited_run", lowcnt, 0);
        // A wrapped counter would reach this limit within a few cycles
        i_cycle_limit = CYC_W'(4470);
        lowcnt = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (!o_core_en) lowcnt++;
        end
        chk("counter_saturated", lowcnt, 0);
        i_cycle_limit = '0;
        i_core_pc = 8'd2;
        step();
        chk("unlimited_halt", {o_done, o_timeout, o_core_en}, 3'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bh_run_ctrl.md
# bh_run_ctrl

Run controller for the brainhack core. Loads a program from a host valid/ready stream into program memory and clears all tape memory. It then releases the core from reset and lets it execute until the program counter runs off the end of the loaded program or a cycle budget expires. It owns the write ports of the program and tape RAMs and the core's reset/enable lines; the core only reads those RAMs while this block is in RUN.

## Interface
- INSTR_W, 3, instruction width (matches core instruction register)
- PRG_AW, 8, program memory address width
- TAPE_AW, 8, tape address width
- TAPE_DW, 8, tape cell width
- CYC_W, 16, cycle counter / budget width

- i_clock  in  1  single clock; all state changes on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  begin load of a new program (sampled in IDLE and HALT only)
- i_in_valid  in  1  host instruction beat valid
- i_in_data  in  INSTR_W  instruction
- i_in_last  in  1  beat is last instruction of program
- o_in_ready  out  1  controller accepts beat
- o_prg_we / o_prg_addr / o_prg_data  out  1 / PRG_AW / INSTR_W  program RAM write port
- o_tape_we / o_tape_addr / o_tape_data  out  1 / TAPE_AW / TAPE_DW  tape RAM write port
- i_core_pc  in  PRG_AW  core program counter
- o_core_rst  out  1  holds core (PC, IR, SP, PTR) in reset
- o_core_en  out  1  core clock enable
- i_cycle_limit  in  CYC_W  run budget; 0 = unlimited
- o_prg_len  out  PRG_AW  number of instructions loaded
- o_busy / o_done / o_timeout  out  1  status

## Operation
- States: IDLE, LOAD, CLEAR, RUN, HALT.
- IDLE: i_start -> LOAD; load address and o_prg_len cleared to 0.
- LOAD: o_in_ready = 1 while fewer than 2^PRG_AW-1 beats accepted. Each accepted beat (valid & ready) writes address = beat index and increments o_prg_len. The beat at index 2^PRG_AW-2 is treated as last regardless of i_in_last. Last beat -> CLEAR.
- CLEAR: writes 0 to tape addresses 0 .. 2^TAPE_AW-1 in ascending order, one per cycle, then -> RUN.
- RUN: o_core_rst = 0, o_core_en = 1. The cycle counter starts at 0 and increments each RUN cycle, saturating at all-ones.
  - i_core_pc == o_prg_len -> HALT, o_timeout = 0.
  - Otherwise, limit != 0 and counter + 1 == limit -> HALT, o_timeout = 1.
  - If both conditions occur in the same cycle, PC completion wins.
- HALT: o_done = 1, core held in reset. o_timeout and o_prg_len hold. i_start -> LOAD and clears o_done and o_timeout.
- o_busy = 1 in LOAD, CLEAR, RUN.
- o_core_rst = 1 and o_core_en = 0 in every state except RUN.
- i_start in LOAD, CLEAR, or RUN is ignored. i_in_valid outside LOAD is ignored (ready = 0).
- o_prg_len wraps never: its maximum is 2^PRG_AW-1, so the halt PC is always reachable.

## Timing
- Reset (async): state IDLE.
  - All write enables, addresses, and data outputs = 0.
  - o_core_rst = 1, o_core_en = 0.
  - o_prg_len = 0, counter = 0.
  - o_busy = o_done = o_timeout = 0.
- Reset in any state aborts immediately. No further RAM write occurs after reset asserts, and partial loads/clears are discarded.
- o_in_ready is combinational from state and beat count. All other outputs are registered.
- Program writes: a beat accepted at edge k appears as o_prg_we = 1 with its address/data during cycle k+1. Back-to-back beats give one write per cycle.
- Last beat accepted at edge k: the state is CLEAR after edge k. The first tape write (address 0) is in cycle k+1, concurrent with the final program write.
- CLEAR lasts exactly 2^TAPE_AW cycles. RUN is entered on the edge after tape address 2^TAPE_AW-1 is written. o_core_rst falls and o_core_en rises on that same edge.
- Halt decision made on i_core_pc sampled at edge e: o_core_en = 0, o_core_rst = 1, and o_done = 1 from edge e.
- Start to first core cycle: 1 + N + 1 + 2^TAPE_AW edges minimum for an N-beat program, with no stalls on valid.

## Test plan
- Reset values: assert i_reset mid-clock -> all outputs at reset values without waiting for an edge. Release -> IDLE, o_core_rst = 1.
- Load 3 beats (5, 2, 7; last on third), valid stalled one cycle between beats 1 and 2 -> program writes addr 0/1/2 data 5/2/7, o_prg_len = 3. Then exactly 256 tape writes of 0 at addresses 0..255, then o_core_en = 1.
- Completion: after load of 3, drive i_core_pc 0, 1, 2, 3 in RUN -> HALT on the edge sampling 3, o_done = 1, o_timeout = 0, o_core_rst = 1.
- Timeout: i_cycle_limit = 10, i_core_pc held at 0 -> exactly 10 cycles with o_core_en = 1, then o_timeout = 1, o_done = 1. Limit 0 with PC held runs 70000 cycles without halting and the counter saturates.
- Full program: 300 beats offered, i_in_last never set -> 255 accepted, o_in_ready drops, CLEAR entered, o_prg_len = 255. PC 255 then halts.
- Abort and restart: reset during CLEAR at tape address 100 -> no writes after reset. i_start plus a new 1-beat load completes normally. i_start during RUN is ignored. In HALT, a simultaneous PC match and limit expiry gives o_timeout = 0.
